// File: rtl/sm_pkg.sv
// sm_pkg: shared definitions for the sign-magnitude result path.
//   SM_N          result word width (sign in MSB, magnitude below)
//   SM_SIGN_BIT   bit position of the sign within a result word
//   SM_MAG_W      magnitude field width
//   sm_entry_t    stored result entry: sign, magnitude, carry
//   sm_normalize  builds an entry from a raw word, turning -0 into +0
//   sm_saturate   clamps the magnitude to all-ones when carry is set
package sm_pkg;

    localparam int SM_N        = 8;
    localparam int SM_SIGN_BIT = SM_N - 1;
    localparam int SM_MAG_W    = SM_N - 1;

    typedef struct packed {
        logic                sign;
        logic [SM_MAG_W-1:0] magnitude;
        logic                carry;
    } sm_entry_t;

    localparam int SM_ENTRY_W = $bits(sm_entry_t);

    // A zero magnitude always gets a positive sign; the magnitude is kept as-is.
    function automatic sm_entry_t sm_normalize(input logic [SM_N-1:0] word,
                                               input logic            carry);
        sm_entry_t e;
        e.magnitude = word[SM_MAG_W-1:0];
        e.sign      = word[SM_SIGN_BIT] & (|word[SM_MAG_W-1:0]);
        e.carry     = carry;
        return e;
    endfunction

    // On carry the magnitude is clamped to its maximum; sign and carry survive.
    function automatic sm_entry_t sm_saturate(input sm_entry_t e);
        sm_entry_t r;
        r = e;
        if (e.carry) begin
            r.magnitude = '1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_fifo_core.sv
// sm_fifo_core: generic synchronous FIFO (storage, pointers, occupancy).
//   clk_i, rst_i   clock and synchronous active-high reset
//   push_i         write wdata_i (ignored while full)
//   wdata_i        write data
//   pop_i          drop the head entry (ignored while empty)
//   rdata_o        head entry, combinational from storage
//   full_o         occupancy == DEPTH (registered state only)
//   empty_o        occupancy == 0 (registered state only)
// DEPTH must be a power of two so the pointers wrap naturally.
module sm_fifo_core #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (occ_q == (AW+1)'(DEPTH));
    assign empty_o = (occ_q == '0);

    // A push while full is refused even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: an entry is only visible once occupancy covers it.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sm_result_stage.sv
// sm_result_stage: registered output stage behind the sign-magnitude
// add/subtract units. Results are normalised (-0 -> +0), queued in a small
// FIFO and handed downstream with flags, a sticky overflow and a pop counter.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid/o_ready     upstream handshake; i_data word and i_carry bit
//   o_valid/i_ready     downstream handshake; o_data, o_ovf, o_zero, o_neg
//   o_sticky_ovf        set by any accepted carry, cleared by i_clr_sticky
//   o_count             pops since reset, wraps modulo 2^CNT_W
// Optional build macro SM_RESULT_SATURATE_EN: an accepted entry with carry
// stores magnitude all-ones with the input sign instead of the wrapped value.
// N is the width of sm_pkg::SM_N and must stay equal to it.
//
// Handshake: a transfer happens on a rising edge where valid && ready is
// high on that side. o_ready and o_valid depend only on registered
// occupancy, so neither depends combinationally on i_valid or i_ready, and
// a pushed entry is visible on o_valid one cycle after acceptance at the
// earliest.
module sm_result_stage
    import sm_pkg::*;
#(
    parameter int N     = SM_N,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_data,
    input  logic             i_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_data,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_sticky_ovf,
    input  logic             i_clr_sticky,
    output logic [CNT_W-1:0] o_count
);

    sm_entry_t              wr_entry;
    sm_entry_t              head;
    logic [SM_ENTRY_W-1:0]  head_bits;
    logic                   full, empty;
    logic                   push, pop;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       count_q, count_d;

    assign o_ready = !full;
    assign o_valid = !empty;
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    // Normalisation is applied to the raw word first, saturation after it.
    always_comb begin
        wr_entry = sm_normalize(i_data, i_carry);
`ifdef SM_RESULT_SATURATE_EN
        wr_entry = sm_saturate(wr_entry);
`endif
    end

    sm_fifo_core #(
        .WIDTH (SM_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head_bits),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head = sm_entry_t'(head_bits);

    // Head fields are masked while empty so the outputs read zero after reset
    // without having to reset the storage array.
    always_comb begin
        o_data = '0;
        o_ovf  = 1'b0;
        o_zero = 1'b0;
        o_neg  = 1'b0;
        if (o_valid) begin
            o_data = {head.sign, head.magnitude};
            o_ovf  = head.carry;
            o_zero = (head.magnitude == '0);
            o_neg  = head.sign;
        end
    end

    // A carry arriving in the same cycle as a clear leaves the flag set.
    always_comb begin
        sticky_d = (sticky_q && !i_clr_sticky) || (push && i_carry);
        count_d  = pop ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign o_sticky_ovf = sticky_q;
    assign o_count      = count_q;

endmodule

// File: tb/tb_sm_result_stage.sv
// tb_sm_result_stage: randomised and directed stimulus against a queue-based
// reference model of sm_result_stage.
module tb_sm_result_stage;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int W     = N + 3;   // {data, ovf, zero, neg}

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [N-1:0]     i_data;
    logic             i_carry;
    logic             o_valid;
    logic             i_ready;
    logic [N-1:0]     o_data;
    logic             o_ovf;
    logic             o_zero;
    logic             o_neg;
    logic             o_sticky_ovf;
    logic             i_clr_sticky;
    logic [CNT_W-1:0] o_count;

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    sm_result_stage #(
        .N     (N),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_carry      (i_carry),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_ovf        (o_ovf),
        .o_zero       (o_zero),
        .o_neg        (o_neg),
        .o_sticky_ovf (o_sticky_ovf),
        .i_clr_sticky (i_clr_sticky),
        .o_count      (o_count)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    bit  m_sticky = 1'b0;
    int  m_count  = 0;
    bit  mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: sign/magnitude arithmetic straight from the result rules.
    function automatic logic [W-1:0] model(input logic [N-1:0] d, input logic c);
        int unsigned  mag;
        bit           neg;
        logic [N-1:0] word;
        mag = int'(d) % 128;
        neg = (int'(d) >= 128) && (mag != 0);
`ifdef SM_RESULT_SATURATE_EN
        if (c) mag = 127;
`endif
        word = N'((neg ? 128 : 0) + mag);
        return {word, c, (mag == 0), neg};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        if (mon_en) begin
            if (i_rst) begin
                exp_q.delete();
                m_sticky = 1'b0;
                m_count  = 0;
            end else begin
                int  occ;
                bit  acc;
                occ = exp_q.size();
                acc = i_valid && (occ != DEPTH);
                check("o_valid", 32'(o_valid), 32'(occ != 0));
                check("o_ready", 32'(o_ready), 32'(occ != DEPTH));
                check("o_count", 32'(o_count), 32'(m_count % (1 << CNT_W)));
                check("o_sticky_ovf", 32'(o_sticky_ovf), 32'(m_sticky));
                if (occ != 0 && o_valid) begin
                    check("head", 32'({o_data, o_ovf, o_zero, o_neg}), 32'(exp_q[0]));
                    if (i_ready) begin
                        void'(exp_q.pop_front());
                        m_count++;
                    end
                end
                m_sticky = (m_sticky && !i_clr_sticky) || (acc && i_carry);
                if (acc) exp_q.push_back(model(i_data, i_carry));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_push(input logic [N-1:0] d, input logic c);
        bit done;
        done    = 1'b0;
        i_valid = 1'b1;
        i_data  = d;
        i_carry = c;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge i_clk);
            done = o_ready;
            @(posedge i_clk);
            #1;
        end
        if (!done) begin
            failures++;
            $display("FAIL push_timeout: got ready=0 expected ready=1 for data 0x%0h", d);
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge i_clk);
            #1;
            done = (exp_q.size() == 0);
        end
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout: got %0d entries expected 0", exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic post_reset_check();
        @(negedge i_clk);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_ready", 32'(o_ready), 32'd1);
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_ovf", 32'(o_ovf), 32'd0);
        check("rst_o_zero", 32'(o_zero), 32'd0);
        check("rst_o_neg", 32'(o_neg), 32'd0);
        check("rst_o_count", 32'(o_count), 32'd0);
        check("rst_o_sticky", 32'(o_sticky_ovf), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit hold;
        i_rst        = 1'b1;
        i_valid      = 1'b0;
        i_data       = '0;
        i_carry      = 1'b0;
        i_ready      = 1'b0;
        i_clr_sticky = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst  = 1'b0;
        mon_en = 1'b1;
        post_reset_check();

        // single negative result, then count after its pop
        i_ready = 1'b1;
        drive_push(8'h85, 1'b0);
        wait_drain();
        @(negedge i_clk);
        check("count_after_first", 32'(o_count), 32'd1);
        @(posedge i_clk);
        #1;

        // negative zero
        drive_push(8'h80, 1'b0);
        wait_drain();

        // fill to full, refused fifth word, then drain in order
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) drive_push(N'(k), 1'b0);
        @(negedge i_clk);
        check("full_ready", 32'(o_ready), 32'd0);
        @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_data  = 8'h05;
        repeat (3) @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_drain();

        // simultaneous push and pop at occupancy 2
        i_ready = 1'b0;
        drive_push(8'h21, 1'b0);
        drive_push(8'hA2, 1'b0);
        i_ready = 1'b1;
        drive_push(8'h23, 1'b0);
        drive_push(8'hA4, 1'b1);
        drive_push(8'h25, 1'b0);
        wait_drain();

        // sticky set wins over clear; later clear without push
        i_clr_sticky = 1'b1;
        drive_push(8'h05, 1'b1);
        i_clr_sticky = 1'b0;
        @(negedge i_clk);
        check("sticky_set_over_clr", 32'(o_sticky_ovf), 32'd1);
        @(posedge i_clk);
        #1;
        wait_drain();
        i_clr_sticky = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr_sticky = 1'b0;
        @(negedge i_clk);
        check("sticky_cleared", 32'(o_sticky_ovf), 32'd0);
        @(posedge i_clk);
        #1;

        // reset with entries queued
        i_ready = 1'b0;
        drive_push(8'h31, 1'b1);
        drive_push(8'h32, 1'b0);
        drive_push(8'h33, 1'b0);
        pulse_reset();
        post_reset_check();
        i_ready = 1'b1;
        drive_push(8'h10, 1'b0);
        wait_drain();

        // long stream so the counter wraps
        for (int k = 0; k < 260; k++) drive_push(N'($urandom), 1'($urandom_range(0, 1)));
        wait_drain();

        // fully random traffic, holding data while stalled
        for (int k = 0; k < 1500; k++) begin
            @(negedge i_clk);
            hold = i_valid && !o_ready;
            @(posedge i_clk);
            #1;
            if (!hold) begin
                i_valid = 1'($urandom_range(0, 1));
                i_data  = N'($urandom);
                i_carry = ($urandom_range(0, 3) == 0);
            end
            i_ready      = ($urandom_range(0, 2) != 0);
            i_clr_sticky = ($urandom_range(0, 7) == 0);
            i_rst        = ($urandom_range(0, 199) == 0);
        end
        i_rst        = 1'b0;
        i_valid      = 1'b0;
        i_clr_sticky = 1'b0;
        i_ready      = 1'b1;
        wait_drain();
        repeat (2) @(posedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_result_stage.md
Name: sm_result_stage

Overview:
- Registered output stage directly downstream of the sign-magnitude add/subtract units.
- Captures each combinational result word (sign bit in MSB, magnitude below) together with its carry/overflow bit into a small FIFO.
- Normalises negative zero, derives result flags and presents the results to the consumer over a valid/ready handshake.
- Keeps a sticky overflow flag and a delivered-result counter for the control/debug path.

Parameters:
- N, 8, result word width in bits: bit N-1 is the sign, bits N-2:0 are the magnitude.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the delivered-result counter.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream result valid.
- o_ready  out  1  stage can accept a result.
- i_data  in  N  sign-magnitude result word from the add/subtract unit.
- i_carry  in  1  magnitude carry/overflow from the add/subtract unit.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts the head entry.
- o_data  out  N  head result word, after normalisation.
- o_ovf  out  1  carry bit stored with the head entry.
- o_zero  out  1  head magnitude equals 0.
- o_neg  out  1  head sign bit; never 1 when o_zero is 1.
- o_sticky_ovf  out  1  set by any accepted entry with carry = 1.
- i_clr_sticky  in  1  clears o_sticky_ovf.
- o_count  out  CNT_W  number of entries popped since reset; wraps modulo 2^CNT_W.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset clears the read/write pointers, occupancy, o_sticky_ovf and o_count. After reset: o_valid=0, o_ready=1, o_data/o_ovf/o_zero/o_neg=0.
- Push occurs when i_valid && o_ready. Pop occurs when o_valid && i_ready.
- o_ready = (occupancy != DEPTH). It is derived from registered state only; there is no combinational path from i_ready.
- o_valid = (occupancy != 0). There is no bypass: a pushed entry appears on o_valid one cycle after acceptance at the earliest.
- Push and pop in the same cycle leave occupancy unchanged. When full, a push is not accepted, even if a pop happens that cycle.
- o_data/o_ovf/o_zero/o_neg come combinationally from the head entry. Their values while o_valid=0 are don't-care, except immediately after reset.
- Normalisation at write: if i_data[N-2:0] == 0, the stored sign is forced to 0 (-0 becomes +0). The magnitude is stored unchanged.
- Stored fields per entry: normalised word (N bits) and carry (1 bit).
- o_zero = (head magnitude == 0). o_neg = head sign.
- Sticky flag: next value = (o_sticky_ovf && !i_clr_sticky) || (push && i_carry). A set in the same cycle as a clear wins.
- o_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- Pointers wrap modulo DEPTH.
- Reset mid-operation discards all stored entries immediately. Upstream must re-present any result it has not yet handed over.
- Upstream must hold i_data/i_carry stable while i_valid=1 and o_ready=0.

Optional Feature:
- Macro: SM_RESULT_SATURATE_EN.
- Defined: an accepted entry with i_carry=1 stores magnitude all-ones (2^(N-1)-1) with the input sign, and o_ovf=1 is retained.
- Undefined: the wrapped magnitude from the add/subtract unit is stored as-is.
- Negative-zero normalisation always applies to the input word, before saturation.

Decomposition:
- Shared package sm_pkg holds:
  - width constant SM_N;
  - typedef sm_entry_t (struct: sign, magnitude, carry);
  - function sm_normalize (the -0 → +0 rule);
  - function sm_saturate.
- The sign/magnitude field positions in sm_pkg replace ad-hoc macros for new code.
- Natural sub-module: sm_fifo_core, a generic synchronous FIFO holding storage, pointers and occupancy and producing full/empty. sm_result_stage adds normalisation, flags, sticky logic and the counter.

Test Plan:
- Reset then single push i_data=0x85, i_carry=0, i_ready=1 → next cycle o_valid=1, o_data=0x85, o_neg=1, o_zero=0, o_ovf=0; after the pop, o_count=1.
- Push i_data=0x80 → o_data=0x00, o_zero=1, o_neg=0.
- i_ready=0, push 0x01,0x02,0x03,0x04 → o_ready=0 after the 4th; 0x05 presented is not accepted. Raise i_ready → 0x01..0x04 pop in order; o_ready returns the cycle after the first pop.
- Occupancy 2, i_valid=1 and i_ready=1 for 3 cycles → occupancy stays 2 and order is preserved.
- Push 0x05 with i_carry=1 while i_clr_sticky=1 → o_sticky_ovf=1 and o_ovf=1. o_data=0x05 without SM_RESULT_SATURATE_EN, 0x7F with it. With sticky already set and i_clr_sticky=1, no push → o_sticky_ovf=0 next cycle.
- Three entries queued, i_rst=1 for one cycle → o_valid=0, o_ready=1, o_count=0, o_sticky_ovf=0; the next push of 0x10 is delivered first.
